// File: rtl/vga_pkg.sv
// Shared types for the SDRAM line arbiter: FSM states, RGB565 pixel, default burst length.
package vga_pkg;

  localparam int DEFAULT_BURST_LEN = 128;

  typedef enum logic [2:0] {
    IDLE,
    VGA_CMD,
    VGA_DATA,
    CPU_CMD,
    CPU_WAIT,
    TURN
  } arb_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } pixel_t;

endpackage

// File: rtl/sdram_line_arbiter_if.sv
// Command/read-return bus between the arbiter (master) and the SDRAM controller (slave).
interface sdram_line_arbiter_if #(
  parameter int ADDR_W = 24
) ();
  import vga_pkg::*;

  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_cmd_we;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [7:0]        mem_cmd_len;
  logic [15:0]       mem_wdata;
  pixel_t            mem_rdata;
  logic              mem_rvalid;

  modport master (
    output mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_len, mem_wdata,
    input  mem_cmd_ready, mem_rdata, mem_rvalid
  );

  modport slave (
    input  mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_len, mem_wdata,
    output mem_cmd_ready, mem_rdata, mem_rvalid
  );

endinterface

// File: rtl/arb_stats.sv
// VGA burst statistics: completed-burst count and worst line_req-rise-to-grant wait, both saturating.
module arb_stats (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        line_req,
  input  logic        line_grant,
  input  logic        line_done,
  output logic [15:0] stat_bursts,
  output logic [15:0] stat_max_wait
);

  logic        req_q;
  logic        waiting;
  logic [15:0] wait_cnt;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      req_q         <= 1'b0;
      waiting       <= 1'b0;
      wait_cnt      <= '0;
      stat_bursts   <= '0;
      stat_max_wait <= '0;
    end else begin
      req_q <= line_req;
      if (line_done && stat_bursts != 16'hFFFF) stat_bursts <= stat_bursts + 16'd1;

      // wait_cnt holds the cycle distance from the rise cycle, so a grant one cycle later reads 1
      if (line_req && !req_q) begin
        waiting  <= 1'b1;
        wait_cnt <= 16'd1;
      end else if (waiting) begin
        if (line_grant) begin
          waiting <= 1'b0;
          if (wait_cnt > stat_max_wait) stat_max_wait <= wait_cnt;
        end else if (wait_cnt != 16'hFFFF) begin
          wait_cnt <= wait_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/sdram_line_arbiter.sv
// Arbitrates one SDRAM command port between VGA line bursts (priority) and CPU single words.
// Optional statistics block enabled by defining VGA_ARB_STATS_EN.
module sdram_line_arbiter
  import vga_pkg::*;
#(
  parameter int BURST_LEN = DEFAULT_BURST_LEN,
  parameter int ADDR_W    = 24
) (
  input  logic                 clk_sys,
  input  logic                 rst,
  input  logic                 line_req,
  output logic                 line_grant,
  input  logic [ADDR_W-1:0]    line_addr,
  output pixel_t               line_data,
  output logic                 line_valid,
  output logic                 line_done,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [15:0]          cpu_wdata,
  output logic [15:0]          cpu_rdata,
  output logic                 cpu_ack,
  sdram_line_arbiter_if.master mem,
  output logic [15:0]          stat_bursts,
  output logic [15:0]          stat_max_wait
);

  localparam logic [7:0] LEN = 8'(BURST_LEN);

  arb_state_t state;
  logic [7:0] word_cnt;
  logic       cpu_rd_ack;

  // Handshake pulses are decoded from registered state, so they are 0 whenever the FSM idles
  assign line_grant = (state == VGA_CMD) && mem.mem_cmd_ready;
  assign cpu_ack    = cpu_rd_ack || ((state == CPU_CMD) && mem.mem_cmd_ready && mem.mem_cmd_we);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values and the block order cannot change behaviour.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state             <= IDLE;
      word_cnt          <= '0;
      cpu_rd_ack        <= 1'b0;
      cpu_rdata         <= '0;
      line_valid        <= 1'b0;
      line_done         <= 1'b0;
      line_data         <= '0;
      mem.mem_cmd_valid <= 1'b0;
      mem.mem_cmd_we    <= 1'b0;
      mem.mem_cmd_addr  <= '0;
      mem.mem_cmd_len   <= '0;
      mem.mem_wdata     <= '0;
    end else begin
      line_valid <= 1'b0;
      line_done  <= 1'b0;
      cpu_rd_ack <= 1'b0;

      case (state)
        IDLE: begin
          if (line_req) begin
            state             <= VGA_CMD;
            word_cnt          <= '0;
            mem.mem_cmd_valid <= 1'b1;
            mem.mem_cmd_we    <= 1'b0;
            mem.mem_cmd_addr  <= line_addr;
            mem.mem_cmd_len   <= LEN;
            mem.mem_wdata     <= '0;
          end else if (cpu_req) begin
            state             <= CPU_CMD;
            mem.mem_cmd_valid <= 1'b1;
            mem.mem_cmd_we    <= cpu_we;
            mem.mem_cmd_addr  <= cpu_addr;
            mem.mem_cmd_len   <= 8'd1;
            mem.mem_wdata     <= cpu_we ? cpu_wdata : 16'h0000;
          end
        end

        VGA_CMD: begin
          if (mem.mem_cmd_ready) begin
            mem.mem_cmd_valid <= 1'b0;
            state             <= VGA_DATA;
          end
        end

        VGA_DATA: begin
          if (mem.mem_rvalid) begin
            line_valid <= 1'b1;
            line_data  <= mem.mem_rdata;
            word_cnt   <= word_cnt + 8'd1;
            if (word_cnt == LEN - 8'd1) begin
              line_done <= 1'b1;
              state     <= TURN;
            end
          end
        end

        CPU_CMD: begin
          if (mem.mem_cmd_ready) begin
            mem.mem_cmd_valid <= 1'b0;
            state             <= mem.mem_cmd_we ? TURN : CPU_WAIT;
          end
        end

        CPU_WAIT: begin
          if (mem.mem_rvalid) begin
            cpu_rdata  <= mem.mem_rdata;
            cpu_rd_ack <= 1'b1;
            state      <= TURN;
          end
        end

        // One dead cycle lets the served requester drop its request before re-arbitration
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VGA_ARB_STATS_EN
  arb_stats u_stats (
    .clk_sys       (clk_sys),
    .rst           (rst),
    .line_req      (line_req),
    .line_grant    (line_grant),
    .line_done     (line_done),
    .stat_bursts   (stat_bursts),
    .stat_max_wait (stat_max_wait)
  );
`else
  assign stat_bursts   = '0;
  assign stat_max_wait = '0;
`endif

endmodule

// File: tb/tb_sdram_line_arbiter.sv
// Directed self-checking bench for sdram_line_arbiter: bursts, CPU traffic, contention, reset, stats.
module tb_sdram_line_arbiter;

  localparam int BURST = 128;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        line_req;
  logic        line_grant;
  logic [23:0] line_addr;
  logic [15:0] line_data;
  logic        line_valid;
  logic        line_done;
  logic        cpu_req;
  logic        cpu_we;
  logic [23:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic [15:0] stat_bursts;
  logic [15:0] stat_max_wait;

  int n_cmp = 0;
  int n_bad = 0;

  sdram_line_arbiter_if #(.ADDR_W(24)) mem_if ();

  sdram_line_arbiter #(.BURST_LEN(BURST), .ADDR_W(24)) dut (
    .clk_sys       (clk_sys),
    .rst           (rst),
    .line_req      (line_req),
    .line_grant    (line_grant),
    .line_addr     (line_addr),
    .line_data     (line_data),
    .line_valid    (line_valid),
    .line_done     (line_done),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_ack       (cpu_ack),
    .mem           (mem_if),
    .stat_bursts   (stat_bursts),
    .stat_max_wait (stat_max_wait)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [15:0] pix(input logic [23:0] a, input int i);
    return a[15:0] + 16'(i * 37);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 32'({line_grant, line_valid, line_done, cpu_ack,
                               mem_if.mem_cmd_valid, mem_if.mem_cmd_we}), 32'd0);
    check({tag, "_len"},   32'(mem_if.mem_cmd_len),  32'd0);
    check({tag, "_addr"},  32'(mem_if.mem_cmd_addr), 32'd0);
    check({tag, "_wdata"}, 32'(mem_if.mem_wdata),    32'd0);
    check({tag, "_ldata"}, 32'(line_data),           32'd0);
    check({tag, "_rdata"}, 32'(cpu_rdata),           32'd0);
    check({tag, "_stats"}, {stat_bursts, stat_max_wait}, 32'd0);
  endtask

  // Full VGA burst: ready held low for 'stall' cycles, then 128 words with periodic gaps.
  task automatic run_burst(input logic [23:0] addr, input int stall);
    int t, n_stable, n_valid, n_done, done_at, n_err, n_lat, sent, cyc;
    logic prev_rv;
    line_req  = 1'b1;
    line_addr = addr;
    t = 0;
    while (mem_if.mem_cmd_valid !== 1'b1 && t < 400) begin
      step();
      t++;
    end
    check("burst_cmd_valid", 32'(mem_if.mem_cmd_valid), 32'd1);

    // A stray read return while the command waits must be dropped
    if (stall > 0) begin
      mem_if.mem_rvalid = 1'b1;
      mem_if.mem_rdata  = 16'hDEAD;
    end
    n_stable = 0;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk_sys);
      if (mem_if.mem_cmd_addr !== addr || mem_if.mem_cmd_len !== 8'd128 ||
          mem_if.mem_cmd_we !== 1'b0 || mem_if.mem_cmd_valid !== 1'b1 ||
          line_grant !== 1'b0 || line_valid !== 1'b0) n_stable++;
      step();
      mem_if.mem_rvalid = 1'b0;
    end
    if (stall > 0) check("burst_stall_stable", 32'(n_stable), 32'd0);

    mem_if.mem_cmd_ready = 1'b1;
    @(negedge clk_sys);
    check("burst_grant",    32'(line_grant),          32'd1);
    check("burst_addr",     32'(mem_if.mem_cmd_addr), 32'(addr));
    check("burst_len",      32'(mem_if.mem_cmd_len),  32'd128);
    check("burst_we",       32'(mem_if.mem_cmd_we),   32'd0);
    check("burst_no_stray", 32'(line_valid),          32'd0);
    step();
    mem_if.mem_cmd_ready = 1'b0;

    n_valid = 0; n_done = 0; done_at = -1; n_err = 0; n_lat = 0; sent = 0; cyc = 0;
    prev_rv = 1'b0;
    while (n_done == 0 && cyc < 400) begin
      if (sent < BURST && (cyc % 7) != 3) begin
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = pix(addr, sent);
        sent++;
      end else begin
        mem_if.mem_rvalid = 1'b0;
      end
      @(negedge clk_sys);
      if (line_valid !== prev_rv) n_lat++;
      if (line_grant !== 1'b0) n_err++;
      if (line_valid === 1'b1) begin
        if (line_data !== pix(addr, n_valid)) n_err++;
        n_valid++;
      end
      if (line_done === 1'b1) begin
        n_done++;
        done_at = n_valid;
        if (line_valid !== 1'b1) n_err++;
      end
      prev_rv = mem_if.mem_rvalid;
      cyc++;
      step();
    end
    mem_if.mem_rvalid = 1'b0;
    check("burst_words",   32'(n_valid), 32'd128);
    check("burst_done",    32'(n_done),  32'd1);
    check("burst_done_at", 32'(done_at), 32'd128);
    check("burst_data",    32'(n_err),   32'd0);
    check("burst_latency", 32'(n_lat),   32'd0);

    line_req = 1'b0;
    @(negedge clk_sys);
    check("burst_quiet", 32'({line_valid, line_done}), 32'd0);
    step();
  endtask

  // CPU single word; optionally raises line_req while a read waits for data.
  task automatic cpu_txn(input logic we, input logic [23:0] addr, input logic [15:0] wdata,
                         input logic [15:0] rdata, input logic raise_line, input logic [23:0] laddr);
    int t, n_pre;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    t = 0;
    while (!(mem_if.mem_cmd_valid === 1'b1 && mem_if.mem_cmd_len === 8'd1) && t < 400) begin
      step();
      t++;
    end
    mem_if.mem_cmd_ready = 1'b1;
    @(negedge clk_sys);
    check("cpu_cmd_valid", 32'(mem_if.mem_cmd_valid), 32'd1);
    check("cpu_cmd_addr",  32'(mem_if.mem_cmd_addr),  32'(addr));
    check("cpu_cmd_len",   32'(mem_if.mem_cmd_len),   32'd1);
    check("cpu_cmd_we",    32'(mem_if.mem_cmd_we),    32'(we));
    if (we) check("cpu_cmd_wdata", 32'(mem_if.mem_wdata), 32'(wdata));
    check("cpu_ack_hs",    32'(cpu_ack),    32'(we));
    check("cpu_no_grant",  32'(line_grant), 32'd0);
    step();
    mem_if.mem_cmd_ready = 1'b0;

    if (we) begin
      cpu_req = 1'b0;
      @(negedge clk_sys);
      check("cpu_wr_ack_pulse", 32'(cpu_ack), 32'd0);
      step();
    end else begin
      if (raise_line) begin
        line_req  = 1'b1;
        line_addr = laddr;
      end
      n_pre = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk_sys);
        if (mem_if.mem_cmd_valid !== 1'b0 || line_grant !== 1'b0 || cpu_ack !== 1'b0) n_pre++;
        step();
      end
      check("cpu_wait_quiet", 32'(n_pre), 32'd0);
      mem_if.mem_rvalid = 1'b1;
      mem_if.mem_rdata  = rdata;
      @(negedge clk_sys);
      check("cpu_rd_ack_early", 32'(cpu_ack), 32'd0);
      step();
      mem_if.mem_rvalid = 1'b0;
      @(negedge clk_sys);
      check("cpu_rd_ack",      32'(cpu_ack),    32'd1);
      check("cpu_rdata",       32'(cpu_rdata),  32'(rdata));
      check("cpu_rd_no_lval",  32'(line_valid), 32'd0);
      step();
      cpu_req = 1'b0;
      @(negedge clk_sys);
      check("cpu_rd_ack_pulse", 32'(cpu_ack), 32'd0);
    end
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    line_req = 1'b0; line_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_if.mem_cmd_ready = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = '0;
    repeat (3) step();
    @(negedge clk_sys);
    check_all_zero("reset");
    step();
    rst = 1'b0;

    // Read return while idle has no effect
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 16'h1357;
    step();
    mem_if.mem_rvalid = 1'b0;
    @(negedge clk_sys);
    check("idle_drop", 32'({line_valid, cpu_ack, line_data, cpu_rdata}), 32'd0);
    step();

    run_burst(24'h000400, 0);
    run_burst(24'h000800, 5);
    cpu_txn(1'b1, 24'h000020, 16'hBEEF, 16'h0000, 1'b0, 24'h0);

    // Simultaneous requests: VGA first, CPU read afterwards
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000010;
    run_burst(24'h000C00, 0);
    cpu_txn(1'b0, 24'h000010, 16'h0000, 16'h5A5A, 1'b0, 24'h0);

    // line_req during a CPU read waits for the next idle
    cpu_txn(1'b0, 24'h000030, 16'h0000, 16'h1234, 1'b1, 24'h001400);
    run_burst(24'h001400, 0);

    // Reset after the 40th word of a burst
    line_req = 1'b1; line_addr = 24'h001000; mem_if.mem_cmd_ready = 1'b1;
    step();
    @(negedge clk_sys);
    check("rst_burst_grant", 32'(line_grant), 32'd1);
    step();
    mem_if.mem_cmd_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      mem_if.mem_rvalid = 1'b1;
      mem_if.mem_rdata  = pix(24'h001000, i);
      @(negedge clk_sys);
      if (line_done === 1'b1) seen++;
      step();
    end
    mem_if.mem_rvalid = 1'b0;
    @(negedge clk_sys);
    check("rst_word40_valid", 32'(line_valid), 32'd1);
    check("rst_word40_data",  32'(line_data),  32'(pix(24'h001000, 39)));
    rst = 1'b1;
    line_req = 1'b0;
    step();
    @(negedge clk_sys);
    check_all_zero("rst_mid");
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      if (line_done !== 1'b0 || line_valid !== 1'b0) seen++;
      step();
    end
    check("rst_no_done", 32'(seen), 32'd0);
    run_burst(24'h002000, 2);

    // Statistics: grant delays of 2, 7 and 4 cycles after a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_burst(24'h003000, 1);
    run_burst(24'h003400, 6);
    run_burst(24'h003800, 3);
    @(negedge clk_sys);
`ifdef VGA_ARB_STATS_EN
    check("stat_bursts",   32'(stat_bursts),   32'd3);
    check("stat_max_wait", 32'(stat_max_wait), 32'd7);
`else
    check("stat_bursts",   32'(stat_bursts),   32'd0);
    check("stat_max_wait", 32'(stat_max_wait), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_line_arbiter.md
SDRAM_LINE_ARBITER -- requirements
Module: sdram_line_arbiter

Interface
REQ-001 The block SHALL expose the parameter BURST_LEN, default 128, giving the words per VGA line burst (range 1..255).
REQ-002 The block SHALL expose the parameter ADDR_W, default 24, giving the word-address width.
REQ-003 The block SHALL have a single clock and a synchronous, active-high reset; all of the ports below are synchronous to clk_sys.
REQ-004 clk_sys  in  1  100MHz system clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 line_req  in  1  VGA line-burst request, held until line_done.
REQ-007 line_grant  out  1  one-cycle pulse: VGA burst command accepted.
REQ-008 line_addr  in  ADDR_W  VGA burst start word address, valid while line_req is high.
REQ-009 line_data  out  16  burst read data (RGB565).
REQ-010 line_valid  out  1  line_data valid.
REQ-011 line_done  out  1  one-cycle pulse, coincident with the last line_valid.
REQ-012 cpu_req, cpu_we  in  1 each  CPU single-word request and write flag, held until cpu_ack.
REQ-013 cpu_addr  in  ADDR_W;  cpu_wdata  in  16;  cpu_rdata  out  16;  cpu_ack  out  1 (one-cycle pulse).
REQ-014 mem_cmd_valid  out  1;  mem_cmd_ready  in  1;  mem_cmd_we  out  1;  mem_cmd_addr  out  ADDR_W;  mem_cmd_len  out  8;  mem_wdata  out  16.
REQ-015 mem_rdata  in  16;  mem_rvalid  in  1  SDRAM controller read return.
REQ-016 stat_bursts  out  16;  stat_max_wait  out  16  statistics outputs (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, VGA_CMD, VGA_DATA, CPU_CMD, CPU_WAIT and TURN.
REQ-018 In IDLE, line_req SHALL have strict priority over cpu_req; IDLE->VGA_CMD when line_req is high, else IDLE->CPU_CMD when cpu_req is high.
REQ-019 On entry to VGA_CMD the block SHALL latch line_addr into the command address, drive mem_cmd_valid=1, mem_cmd_we=0 and mem_cmd_len=BURST_LEN, and hold these stable until mem_cmd_ready.
REQ-020 In the cycle where mem_cmd_valid and mem_cmd_ready are both high in VGA_CMD, line_grant SHALL pulse and the FSM SHALL move to VGA_DATA.
REQ-021 In VGA_DATA, each mem_rvalid SHALL be forwarded to line_valid/line_data with exactly 1 cycle registered latency, counted by an 8-bit word counter.
REQ-022 line_done SHALL pulse together with the BURST_LEN-th line_valid; the FSM SHALL then go VGA_DATA->TURN.
REQ-023 TURN SHALL last exactly one cycle, ignore all requests, and return to IDLE; this covers the requester's registered release of line_req.
REQ-024 CPU_CMD SHALL drive mem_cmd_len=1, mem_cmd_we=cpu_we and mem_cmd_addr=cpu_addr, plus mem_wdata=cpu_wdata when writing.
REQ-025 CPU write: on the mem_cmd_ready handshake, cpu_ack SHALL pulse and the FSM SHALL go to TURN.
REQ-026 CPU read: on the handshake the FSM SHALL go to CPU_WAIT; on mem_rvalid it SHALL register cpu_rdata, pulse cpu_ack 1 cycle later, and go to TURN.
REQ-027 A CPU transaction in progress SHALL NOT be pre-empted; line_req raised during it SHALL be served on the next IDLE.
REQ-028 mem_rvalid outside VGA_DATA/CPU_WAIT SHALL be dropped with no output effect.
REQ-029 Simultaneous line_req and cpu_req in IDLE SHALL always grant VGA; the CPU SHALL wait for the next IDLE.

Reset
REQ-030 While rst is high the FSM SHALL be IDLE, the counters SHALL be 0, and every output SHALL be 0, including the data outputs.
REQ-031 A reset during any state SHALL abort the transaction; no line_done or cpu_ack SHALL be issued for it.

Configuration
REQ-032 With VGA_ARB_STATS_EN defined, stat_bursts SHALL count completed VGA bursts, saturating at 16'hFFFF.
REQ-033 With VGA_ARB_STATS_EN defined, stat_max_wait SHALL hold the maximum number of cycles from the line_req rise to line_grant, saturating at 16'hFFFF.
REQ-034 Without VGA_ARB_STATS_EN, both stat ports SHALL remain present, be tied to 0, and have no counter logic.

Structure
REQ-035 The shared package vga_pkg SHALL hold the FSM state enumeration, RGB565 pixel typedef and default burst length constant.
REQ-036 One sub-module, arb_stats, SHALL implement the statistics counters; it SHALL be instantiated only under VGA_ARB_STATS_EN.

Verification
REQ-037 VGA burst: line_req=1, line_addr=24'h000400, mem_cmd_ready=1 -> mem_cmd_addr=24'h000400 and len=128, one line_grant, 128 line_valid, line_done on the 128th.
REQ-038 Contention: line_req and cpu_req (read, 24'h000010) rise in the same cycle -> VGA burst completes first, then cpu_ack with cpu_rdata=mem_rdata.
REQ-039 Back-pressure: mem_cmd_ready held low for 5 cycles -> command fields stable throughout, line_grant exactly in the handshake cycle.
REQ-040 Reset mid-burst: rst pulsed after the 40th word -> all outputs 0, no line_done, and the next line_req is served normally.
REQ-041 Stats: with VGA_ARB_STATS_EN, 3 bursts with grant delays of 2, 7 and 4 cycles -> stat_bursts=3, stat_max_wait=7.
